bus_rr_scheduler: RTL and testbench

BUS_RR_SCHEDULER -- requirements
Module: bus_rr_scheduler

---
 rtl/bus_rr_scheduler.sv | 168 ++++++++++++++++
 tb/tb_bus_rr_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bus_rr_scheduler
// Purpose  : Round-robin scheduler for a shared packet bus. In IDLE it picks
//            the next pending driver (search starts one past the last grant),
//            pops that driver's head packet in POP, and in XFER presents the
//            packet to every receiver with a push mask chosen from the
//            destination ID: unicast, broadcast (all but the source), or
//            drop for unknown IDs. One packet moves every three cycles at best.
// Ports    : clk       - clock, rising edge
//            reset     - asynchronous active-low reset, release synchronized
//            enable    - allow new arbitration; the current packet always ends
//            pndng     - per-driver packet pending
//            D_pop     - per-driver head packet, driver i at [i*pckg_size +: pckg_size]
//            pop       - one-hot consume strobe to the granted driver
//            push      - per-receiver write strobe
//            D_push    - packet to every receiver (same value on each lane)
//            busy      - FSM not in IDLE
//            grant_id  - index of the last granted driver
//            drop      - packet with an unknown destination was discarded
// Revision : 1.0 - initial release
// ============================================================================
module bus_rr_scheduler #(
  parameter int         drvrs     = 4,
  parameter int         pckg_size = 16,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [drvrs-1:0]             pndng,
  input  logic [drvrs*pckg_size-1:0]   D_pop,
  output logic [drvrs-1:0]             pop,
  output logic [drvrs-1:0]             push,
  output logic [drvrs*pckg_size-1:0]   D_push,
  output logic                         busy,
  output logic [3:0]                   grant_id,
  output logic                         drop
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_POP  = 2'd1;
  localparam logic [1:0] c_XFER = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [1:0]           r_rst_sync;
  logic [3:0]           r_grant;
  logic [pckg_size-1:0] r_pkt;
  logic [3:0]           w_winner;
  logic                 w_found;
  logic                 w_arb_ok;
  logic [7:0]           w_id;
  logic                 w_is_unicast;
  logic                 w_is_bcast;
  logic [drvrs-1:0]     w_uni_mask;
  logic [drvrs-1:0]     w_bc_mask;
  logic [drvrs-1:0]     w_grant_oh;
  logic [pckg_size-1:0] w_sel_pkt;

  // Reset assertion is immediate; release has to ripple through two flops
  // before the FSM is allowed to leave IDLE, so a reset edge near a clock
  // edge can never launch a half-initialised arbitration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_arb_ok = enable & r_rst_sync[1] & (|pndng);

  // Rotating-priority search: candidate k is (last grant + 1 + k) mod drvrs,
  // the first pending candidate wins.
  always_comb begin
    w_winner = r_grant;
    w_found  = 1'b0;
    for (int k = 0; k < drvrs; k++) begin
      if (!w_found && pndng[(int'(r_grant) + 1 + k) % drvrs]) begin
        w_found  = 1'b1;
        w_winner = 4'((int'(r_grant) + 1 + k) % drvrs);
      end
    end
  end

  assign w_sel_pkt    = D_pop[int'(r_grant)*pckg_size +: pckg_size];
  assign w_id         = r_pkt[pckg_size-1 -: 8];
  assign w_is_unicast = (32'(w_id) < 32'(drvrs));
  assign w_is_bcast   = (w_id == broadcast);

  generate
    for (genvar i = 0; i < drvrs; i++) begin : g_dec
      assign w_uni_mask[i] = (w_id == 8'(i));
      assign w_bc_mask[i]  = (r_grant != 4'(i));
      assign w_grant_oh[i] = (r_grant == 4'(i));
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = c_IDLE;
    case (r_state)
      c_IDLE:  w_next_state = w_arb_ok ? c_POP : c_IDLE;
      c_POP:   w_next_state = c_XFER;
      c_XFER:  w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Grant index and packet register. grant_id resets to drvrs-1 so the
  // first search after reset begins at driver 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant <= 4'(drvrs - 1);
      r_pkt   <= '0;
    end else begin
      if (r_state == c_IDLE && w_arb_ok) begin
        r_grant <= w_winner;
      end
      if (r_state == c_POP) begin
        r_pkt <= w_sel_pkt;
      end
    end
  end

  // Output logic
  always_comb begin
    pop  = '0;
    push = '0;
    drop = 1'b0;
    case (r_state)
      c_POP: pop = w_grant_oh;
      c_XFER: begin
        if (w_is_unicast) begin
          push = w_uni_mask;
        end else if (w_is_bcast) begin
          push = w_bc_mask;
        end else begin
          drop = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy     = (r_state != c_IDLE);
  assign grant_id = r_grant;

  // The packet register is only written in POP, so every lane holds the
  // last transferred packet between transfers.
  generate
    for (genvar i = 0; i < drvrs; i++) begin : g_dpush
      assign D_push[i*pckg_size +: pckg_size] = r_pkt;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bus_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_rr_scheduler
// Purpose  : Self-checking bench for bus_rr_scheduler (drvrs=4, 16-bit
//            packets). Expected transfers are queued when stimulus is driven
//            and compared when the scheduler pops and pushes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_rr_scheduler;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic [N-1:0]   pndng;
  logic [N*W-1:0] d_pop;
  logic [N-1:0]   pop;
  logic [N-1:0]   push;
  logic [N*W-1:0] d_push;
  logic           busy;
  logic [3:0]     grant_id;
  logic           drop;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]   src;
    logic [N-1:0] pop;
    logic [N-1:0] push;
    logic [W-1:0] data;
    logic         drop;
  } exp_t;

  exp_t sb[$];

  bus_rr_scheduler #(
    .drvrs     (N),
    .pckg_size (W),
    .broadcast (8'hFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .pndng    (pndng),
    .D_pop    (d_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (d_push),
    .busy     (busy),
    .grant_id (grant_id),
    .drop     (drop)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({pop, push, drop, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: pop=%b push=%b drop=%b busy=%b, want all 0", pop, push, drop, busy);
    end
    n_cmp++;
    if (d_push !== '0) begin
      n_err++;
      $display("FAIL reset_dpush: got %h want 0", d_push);
    end
    n_cmp++;
    if (grant_id !== 4'd3) begin
      n_err++;
      $display("FAIL reset_grant: got %0d want 3", grant_id);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_unicast();
    exp_t e;
    d_pop[1*W +: W] = 16'h0312;
    pndng = 4'b0010;
    sb.push_back('{src: 4'd1, pop: 4'b0010, push: 4'b1000, data: 16'h0312, drop: 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front();
    pndng = 4'b0000;
    n_cmp++;
    if (pop !== e.pop || push !== 4'b0000 || grant_id !== e.src) begin
      n_err++;
      $display("FAIL uni_pop: pop=%b push=%b grant=%0d want pop=%b push=0000 grant=%0d", pop, push, grant_id, e.pop, e.src);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (push !== e.push || d_push !== {N{e.data}} || drop !== e.drop || pop !== 4'b0000) begin
      n_err++;
      $display("FAIL uni_push: push=%b data=%h drop=%b pop=%b want push=%b data=%h drop=%b", push, d_push[W-1:0], drop, pop, e.push, e.data, e.drop);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || push !== 4'b0000 || d_push !== {N{e.data}}) begin
      n_err++;
      $display("FAIL uni_hold: busy=%b push=%b data=%h want busy=0 push=0000 data=%h", busy, push, d_push[W-1:0], e.data);
    end
  endtask

  task automatic test_broadcast();
    exp_t e;
    d_pop[2*W +: W] = 16'hFFA5;
    pndng = 4'b0100;
    sb.push_back('{src: 4'd2, pop: 4'b0100, push: 4'b1011, data: 16'hFFA5, drop: 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front();
    pndng = 4'b0000;
    n_cmp++;
    if (pop !== e.pop || grant_id !== e.src) begin
      n_err++;
      $display("FAIL bc_pop: pop=%b grant=%0d want pop=%b grant=%0d", pop, grant_id, e.pop, e.src);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (push !== e.push || d_push !== {N{e.data}} || drop !== e.drop) begin
      n_err++;
      $display("FAIL bc_push: push=%b data=%h drop=%b want push=%b data=%h drop=0", push, d_push[W-1:0], drop, e.push, e.data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_invalid();
    exp_t e;
    d_pop[0*W +: W] = 16'h07AA;
    pndng = 4'b0001;
    sb.push_back('{src: 4'd0, pop: 4'b0001, push: 4'b0000, data: 16'h07AA, drop: 1'b1});
    @(posedge clk); #1;
    e = sb.pop_front();
    pndng = 4'b0000;
    n_cmp++;
    if (pop !== e.pop || grant_id !== e.src || drop !== 1'b0) begin
      n_err++;
      $display("FAIL inv_pop: pop=%b grant=%0d drop=%b want pop=%b grant=%0d drop=0", pop, grant_id, drop, e.pop, e.src);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (push !== e.push || drop !== e.drop) begin
      n_err++;
      $display("FAIL inv_drop: push=%b drop=%b want push=%b drop=%b", push, drop, e.push, e.drop);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (drop !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL inv_drop_len: drop=%b busy=%b want drop=0 busy=0", drop, busy);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int t;
    d_pop[2*W +: W] = 16'h0155;
    pndng = 4'b0100;
    @(posedge clk); #1;
    n_cmp++;
    if (pop !== 4'b0100) begin
      n_err++;
      $display("FAIL rm_pop: pop=%b want 0100", pop);
    end
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if ({pop, push, drop, busy} !== '0 || d_push !== '0 || grant_id !== 4'd3) begin
      n_err++;
      $display("FAIL rm_clear: pop=%b push=%b drop=%b busy=%b data=%h grant=%0d want zeros grant=3", pop, push, drop, busy, d_push[W-1:0], grant_id);
    end
    repeat (2) begin
      @(posedge clk); #1;
      n_cmp++;
      if (push !== 4'b0000 || pop !== 4'b0000) begin
        n_err++;
        $display("FAIL rm_nopush: push=%b pop=%b want 0000", push, pop);
      end
    end
    reset = 1'b1;
    sb.push_back('{src: 4'd2, pop: 4'b0100, push: 4'b0010, data: 16'h0155, drop: 1'b0});
    t = 0;
    while (pop === 4'b0000 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    e = sb.pop_front();
    pndng = 4'b0000;
    n_cmp++;
    if (pop !== e.pop || grant_id !== e.src) begin
      n_err++;
      $display("FAIL rm_regrant: pop=%b grant=%0d want pop=%b grant=%0d", pop, grant_id, e.pop, e.src);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (push !== e.push || d_push !== {N{e.data}}) begin
      n_err++;
      $display("FAIL rm_push: push=%b data=%h want push=%b data=%h", push, d_push[W-1:0], e.push, e.data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    exp_t e;
    int   ptr;
    int   t;
    for (int i = 0; i < N; i++) begin
      d_pop[i*W +: W] = {8'((i + 1) % N), 8'(8'hC0 + i)};
    end
    enable = 1'b1;
    do_reset();
    pndng = 4'b1111;
    ptr = N - 1;
    for (int k = 0; k < 12; k++) begin
      ptr = (ptr + 1) % N;
      sb.push_back('{src: 4'(ptr), pop: 4'(1 << ptr), push: 4'(1 << ((ptr + 1) % N)),
                     data: {8'((ptr + 1) % N), 8'(8'hC0 + ptr)}, drop: 1'b0});
    end
    t = 0;
    while (pop === 4'b0000 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    n_cmp++;
    if (pop === 4'b0000) begin
      n_err++;
      $display("FAIL fair_start: no pop within 20 cycles of reset release");
    end
    for (int k = 0; k < 12; k++) begin
      e = sb.pop_front();
      n_cmp++;
      if (pop !== e.pop || grant_id !== e.src) begin
        n_err++;
        $display("FAIL fair_grant[%0d]: pop=%b grant=%0d want pop=%b grant=%0d", k, pop, grant_id, e.pop, e.src);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (push !== e.push || d_push !== {N{e.data}} || pop !== 4'b0000) begin
        n_err++;
        $display("FAIL fair_push[%0d]: push=%b data=%h pop=%b want push=%b data=%h", k, push, d_push[W-1:0], pop, e.push, e.data);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (pop !== 4'b0000 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL fair_idle[%0d]: pop=%b busy=%b want 0000/0", k, pop, busy);
      end
      if (k == 11) begin
        pndng = 4'b0000;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_enable();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      d_pop[i*W +: W] = {8'((i + 1) % N), 8'(8'h50 + i)};
    end
    enable = 1'b0;
    pndng  = 4'b1111;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (pop !== 4'b0000 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL en_gate[%0d]: pop=%b busy=%b want 0000/0", c, pop, busy);
      end
    end
    sb.push_back('{src: 4'd0, pop: 4'b0001, push: 4'b0010, data: 16'h0150, drop: 1'b0});
    enable = 1'b1;
    @(posedge clk); #1;
    e = sb.pop_front();
    n_cmp++;
    if (pop !== e.pop || grant_id !== e.src) begin
      n_err++;
      $display("FAIL en_pop: pop=%b grant=%0d want pop=%b grant=%0d", pop, grant_id, e.pop, e.src);
    end
    enable = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (push !== e.push || d_push !== {N{e.data}}) begin
      n_err++;
      $display("FAIL en_finish: push=%b data=%h want push=%b data=%h", push, d_push[W-1:0], e.push, e.data);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (pop !== 4'b0000 || busy !== 1'b0 || push !== 4'b0000) begin
        n_err++;
        $display("FAIL en_hold[%0d]: pop=%b busy=%b push=%b want idle", c, pop, busy, push);
      end
    end
    pndng = 4'b0000;
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    pndng  = '0;
    d_pop  = '0;
    @(posedge clk); #1;
    test_reset();
    test_unicast();
    test_broadcast();
    test_invalid();
    test_reset_mid();
    test_fairness();
    test_enable();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d expected transfers never seen, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
